// File: rtl/fp_addsub_sequencer.sv
// Multi-cycle single-precision add/subtract controller: compare/swap, align,
// add/subtract through one shared significand adder, then iterative normalize.
module fp_addsub_sequencer #(
    parameter int EXP_WIDTH  = 8,
    parameter int MENT_WIDTH = 23
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          start_in,
    input  logic [EXP_WIDTH+MENT_WIDTH:0] operand1_in,
    input  logic [EXP_WIDTH+MENT_WIDTH:0] operand2_in,
    input  logic                          opcode_in,
    output logic                          ready_out,
    output logic                          busy_out,
    output logic                          done_out,
    output logic [EXP_WIDTH+MENT_WIDTH:0] result_out
);
    localparam int W     = 1 + EXP_WIDTH + MENT_WIDTH;
    localparam int SIG_W = MENT_WIDTH + 1;
    localparam int SUM_W = MENT_WIDTH + 2;
    localparam int XW    = EXP_WIDTH + 1;
    localparam logic [XW-1:0] EXP_MAX = {1'b0, {EXP_WIDTH{1'b1}}};
    localparam logic [XW-1:0] SIG_W_X = XW'(SIG_W);

    typedef enum logic [2:0] {IDLE, CMP, ALIGN, ADD, NORM, DONE} state_t;

    state_t           state, next_state;
    logic             sign_a, sign_b;
    logic [XW-1:0]    exp_a, exp_b, exp_diff, exp_inc, exp_dec;
    logic [SIG_W-1:0] sig_a, sig_b;
    logic [SUM_W-1:0] sum;
    logic [W-1:0]     result_r, norm_result;
    logic             swap;

    // Zero exponent means zero: denormal mantissas are flushed at capture.
    function automatic logic [SIG_W-1:0] unpack_sig(input logic [EXP_WIDTH-1:0] e,
                                                    input logic [MENT_WIDTH-1:0] m);
        return (e == '0) ? '0 : {1'b1, m};
    endfunction

    assign swap    = {exp_b, sig_b} > {exp_a, sig_a};
    assign exp_inc = exp_a + XW'(1);
    assign exp_dec = exp_a - XW'(1);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= next_state;
    end

    always_comb begin
        next_state  = state;
        norm_result = '0;
        case (state)
            IDLE:  if (start_in) next_state = CMP;
            CMP:   next_state = ALIGN;
            ALIGN: next_state = ADD;
            ADD:   next_state = NORM;
            NORM: begin
                if (sum == '0) begin
                    next_state = DONE;
                end else if (sum[SUM_W-1]) begin
                    if (exp_inc == EXP_MAX) begin
                        next_state  = DONE;
                        norm_result = {sign_a, {EXP_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
                    end
                end else if (!sum[SUM_W-2]) begin
                    if (exp_dec == '0) begin
                        next_state  = DONE;
                        norm_result = {sign_a, {(W-1){1'b0}}};
                    end
                end else begin
                    next_state  = DONE;
                    norm_result = {sign_a, exp_a[EXP_WIDTH-1:0], sum[MENT_WIDTH-1:0]};
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: each state owns exactly one step of the mantissa path.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            exp_a    <= '0;
            exp_b    <= '0;
            exp_diff <= '0;
            sig_a    <= '0;
            sig_b    <= '0;
            sum      <= '0;
            result_r <= '0;
        end else begin
            case (state)
                IDLE: if (start_in) begin
                    sign_a <= operand1_in[W-1];
                    exp_a  <= {1'b0, operand1_in[W-2:MENT_WIDTH]};
                    sig_a  <= unpack_sig(operand1_in[W-2:MENT_WIDTH], operand1_in[MENT_WIDTH-1:0]);
                    sign_b <= operand2_in[W-1] ^ opcode_in;
                    exp_b  <= {1'b0, operand2_in[W-2:MENT_WIDTH]};
                    sig_b  <= unpack_sig(operand2_in[W-2:MENT_WIDTH], operand2_in[MENT_WIDTH-1:0]);
                end
                CMP: begin
                    if (swap) begin
                        sign_a   <= sign_b;
                        sign_b   <= sign_a;
                        exp_a    <= exp_b;
                        exp_b    <= exp_a;
                        sig_a    <= sig_b;
                        sig_b    <= sig_a;
                        exp_diff <= exp_b - exp_a;
                    end else begin
                        exp_diff <= exp_a - exp_b;
                    end
                end
                ALIGN: sig_b <= (exp_diff >= SIG_W_X) ? '0 : (sig_b >> exp_diff);
                ADD: begin
                    // The swap guarantees A >= B, so the two's-complement difference is non-negative.
                    if (sign_a == sign_b) sum <= {1'b0, sig_a} + {1'b0, sig_b};
                    else                  sum <= {1'b0, sig_a} + ~{1'b0, sig_b} + SUM_W'(1);
                end
                NORM: begin
                    if (next_state == DONE) begin
                        result_r <= norm_result;
                    end else if (sum[SUM_W-1]) begin
                        sum   <= sum >> 1;
                        exp_a <= exp_inc;
                    end else begin
                        sum   <= sum << 1;
                        exp_a <= exp_dec;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_out  = (state == IDLE);
    assign busy_out   = (state != IDLE);
    assign done_out   = (state == DONE);
    assign result_out = result_r;

endmodule
